// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and the
// prescaler width helper.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bits needed to count 0..prescale-1, never less than one bit.
    function automatic int presc_width(input int prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and status bundle of the countdown timer. The controller drives
// load/start/pause; the timer returns count, busy, done and state.
interface countdown_timer_if
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH = 8
) ();

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    state_t           state;

    modport master (
        output load, load_val, start, pause,
        input  count, busy, done, state
    );

    modport slave (
        input  load, load_val, start, pause,
        output count, busy, done, state
    );

endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Free-running prescaler that emits a one-cycle enable tick every PRESCALE
// enabled cycles; the count holds whenever en is low.
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic RSTN,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = presc_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter stepped by tick_prescaler, with optional auto-reload
// and a registered one-cycle done pulse on expiry.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int PRESCALE    = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input logic               clk,
    input logic               RSTN,
    countdown_timer_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             presc_en, presc_clr, tick;

    // The prescaler keeps running through a pause request so that a tick
    // landing on the pause edge is fully applied; it freezes in PAUSED.
    assign presc_en  = (state_q == ST_RUN) && !bus.load;
    assign presc_clr = bus.load ||
                       (bus.start && (state_q == ST_IDLE || state_q == ST_DONE));

    tick_prescaler #(.PRESCALE(PRESCALE)) u_presc (
        .clk  (clk),
        .RSTN (RSTN),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (bus.load) begin
            count_d  = bus.load_val;
            reload_d = bus.load_val;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (count_q != '0) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (tick) begin
                        if (count_q == WIDTH'(1)) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD && reload_q != '0) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_DONE;
                            end
                        end else if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                        end
                    end
                    // Expiry into DONE takes precedence over a pause request.
                    if (bus.pause && state_d == ST_RUN) begin
                        state_d = ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        if (reload_q != '0) begin
                            count_d = reload_q;
                            state_d = ST_RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign bus.count = count_q;
    assign bus.state = state_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: dut0 (PRESCALE=4, one-shot) and
// dut1 (PRESCALE=4, auto-reload) against hand-computed expectations.
module tb_countdown_timer;
    import countdown_timer_pkg::*;

    logic clk;
    logic RSTN;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    countdown_timer_if #(.WIDTH(8)) if0 ();
    countdown_timer_if #(.WIDTH(8)) if1 ();

    countdown_timer #(.WIDTH(8), .PRESCALE(4), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .RSTN(RSTN), .bus(if0)
    );
    countdown_timer #(.WIDTH(8), .PRESCALE(4), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .RSTN(RSTN), .bus(if1)
    );

    typedef struct {
        int         dut;
        int         cyc;
        int         tid;
        logic [7:0] cnt;
        state_t     st;
        logic       busy;
        logic       done;
    } snap_t;

    snap_t snap_q[$];
    int    done_q0[$];
    int    done_q1[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int d, input logic ld, input logic [7:0] v,
                         input logic st, input logic pz);
        if (d == 0) begin
            if0.load = ld; if0.load_val = v; if0.start = st; if0.pause = pz;
        end else begin
            if1.load = ld; if1.load_val = v; if1.start = st; if1.pause = pz;
        end
        tick_n(1);
        if (d == 0) begin
            if0.load = 1'b0; if0.start = 1'b0; if0.pause = 1'b0;
        end else begin
            if1.load = 1'b0; if1.start = 1'b0; if1.pause = 1'b0;
        end
    endtask

    // Expected outputs after the most recent clock edge.
    task automatic expect_now(input int d, input int t, input int c,
                              input state_t s, input logic b, input logic dn);
        snap_q.push_back('{dut: d, cyc: cyc, tid: t, cnt: 8'(c),
                           st: s, busy: b, done: dn});
    endtask

    task automatic expect_done(input int d, input int at);
        if (d == 0) done_q0.push_back(at);
        else        done_q1.push_back(at);
    endtask

    snap_t      e;
    logic [7:0] g_cnt;
    state_t     g_st;
    logic       g_b, g_d;
    int         dexp;

    always @(negedge clk) begin
        if (if0.done === 1'b1) begin
            checks++;
            if (done_q0.size() == 0) begin
                errors++;
                $display("FAIL done0: unexpected pulse at cyc %0d", cyc);
            end else begin
                dexp = done_q0.pop_front();
                if (dexp != cyc) begin
                    errors++;
                    $display("FAIL done0: pulse at cyc %0d, want cyc %0d", cyc, dexp);
                end
            end
        end
        if (if1.done === 1'b1) begin
            checks++;
            if (done_q1.size() == 0) begin
                errors++;
                $display("FAIL done1: unexpected pulse at cyc %0d", cyc);
            end else begin
                dexp = done_q1.pop_front();
                if (dexp != cyc) begin
                    errors++;
                    $display("FAIL done1: pulse at cyc %0d, want cyc %0d", cyc, dexp);
                end
            end
        end
        while (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
            e = snap_q.pop_front();
            if (e.dut == 0) begin
                g_cnt = if0.count; g_st = if0.state; g_b = if0.busy; g_d = if0.done;
            end else begin
                g_cnt = if1.count; g_st = if1.state; g_b = if1.busy; g_d = if1.done;
            end
            checks++;
            if (e.cyc != cyc ||
                {g_cnt, g_st, g_b, g_d} !== {e.cnt, e.st, e.busy, e.done}) begin
                errors++;
                $display("FAIL snap t%0d dut%0d cyc %0d: got count=%0d state=%0d busy=%b done=%b, want count=%0d state=%0d busy=%b done=%b (cyc %0d)",
                         e.tid, e.dut, cyc, g_cnt, g_st, g_b, g_d,
                         e.cnt, e.st, e.busy, e.done, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int e0;

    initial begin
        RSTN = 1'b0;
        if0.load = 1'b0; if0.load_val = '0; if0.start = 1'b0; if0.pause = 1'b0;
        if1.load = 1'b0; if1.load_val = '0; if1.start = 1'b0; if1.pause = 1'b0;
        tick_n(2);
        RSTN = 1'b1;
        expect_now(0, 0, 0, ST_IDLE, 1'b0, 1'b0);
        expect_now(1, 0, 0, ST_IDLE, 1'b0, 1'b0);

        // Test 1: load 3, start, steps at RUN edges 4/8/12.
        drive(0, 1'b1, 8'd3, 1'b0, 1'b0);
        expect_now(0, 1, 3, ST_IDLE, 1'b0, 1'b0);
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
        e0 = cyc;
        expect_now(0, 1, 3, ST_RUN, 1'b1, 1'b0);
        expect_done(0, e0 + 12);
        for (int i = 1; i <= 12; i++) begin
            tick_n(1);
            if (i < 12) expect_now(0, 1, 3 - i / 4, ST_RUN, 1'b1, 1'b0);
            else        expect_now(0, 1, 0, ST_DONE, 1'b0, 1'b1);
        end
        tick_n(1);
        expect_now(0, 1, 0, ST_DONE, 1'b0, 1'b0);

        // Test 2: pause on the 6th RUN edge, hold, resume; done at RUN edge 20.
        drive(0, 1'b1, 8'd5, 1'b0, 1'b0);
        expect_now(0, 2, 5, ST_IDLE, 1'b0, 1'b0);
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
        expect_now(0, 2, 5, ST_RUN, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick_n(1);
            expect_now(0, 2, 5 - i / 4, ST_RUN, 1'b1, 1'b0);
        end
        drive(0, 1'b0, 8'd0, 1'b0, 1'b1);
        expect_now(0, 2, 4, ST_PAUSED, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            if0.pause = (i <= 3);
            tick_n(1);
            expect_now(0, 2, 4, ST_PAUSED, 1'b0, 1'b0);
        end
        if0.pause = 1'b0;
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
        e0 = cyc;
        expect_now(0, 2, 4, ST_RUN, 1'b1, 1'b0);
        expect_done(0, e0 + 14);
        for (int j = 1; j <= 14; j++) begin
            tick_n(1);
            if (j < 14) expect_now(0, 2, 4 - (j + 2) / 4, ST_RUN, 1'b1, 1'b0);
            else        expect_now(0, 2, 0, ST_DONE, 1'b0, 1'b1);
        end

        // Test 3: zero load, restart with empty reload, then reload of 7.
        drive(0, 1'b1, 8'd0, 1'b0, 1'b0);
        expect_now(0, 3, 0, ST_IDLE, 1'b0, 1'b0);
        expect_done(0, cyc + 1);
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
        expect_now(0, 3, 0, ST_DONE, 1'b0, 1'b1);
        tick_n(1);
        expect_now(0, 3, 0, ST_DONE, 1'b0, 1'b0);
        expect_done(0, cyc + 1);
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
        expect_now(0, 3, 0, ST_DONE, 1'b0, 1'b1);
        tick_n(1);
        expect_now(0, 3, 0, ST_DONE, 1'b0, 1'b0);
        drive(0, 1'b1, 8'd7, 1'b0, 1'b0);
        expect_now(0, 3, 7, ST_IDLE, 1'b0, 1'b0);
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
        e0 = cyc;
        expect_now(0, 3, 7, ST_RUN, 1'b1, 1'b0);
        expect_done(0, e0 + 28);
        tick_n(27);
        expect_now(0, 3, 1, ST_RUN, 1'b1, 1'b0);
        tick_n(1);
        expect_now(0, 3, 0, ST_DONE, 1'b0, 1'b1);
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
        expect_now(0, 3, 7, ST_RUN, 1'b1, 1'b0);
        tick_n(2);
        expect_now(0, 3, 7, ST_RUN, 1'b1, 1'b0);

        // Test 4: load beats start and pause in the same cycle.
        drive(0, 1'b1, 8'd9, 1'b1, 1'b1);
        expect_now(0, 4, 9, ST_IDLE, 1'b0, 1'b0);
        tick_n(1);
        expect_now(0, 4, 9, ST_IDLE, 1'b0, 1'b0);

        // Test 5: reset at count 4 mid-run, then start goes straight to DONE.
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
        expect_now(0, 5, 9, ST_RUN, 1'b1, 1'b0);
        tick_n(20);
        expect_now(0, 5, 4, ST_RUN, 1'b1, 1'b0);
        RSTN = 1'b0;
        tick_n(1);
        RSTN = 1'b1;
        expect_now(0, 5, 0, ST_IDLE, 1'b0, 1'b0);
        expect_done(0, cyc + 1);
        drive(0, 1'b0, 8'd0, 1'b1, 1'b0);
        expect_now(0, 5, 0, ST_DONE, 1'b0, 1'b1);
        tick_n(1);
        expect_now(0, 5, 0, ST_DONE, 1'b0, 1'b0);

        // Test 6: auto-reload, done at RUN edges 8 and 16, count 2,1,2,1,2.
        drive(1, 1'b1, 8'd2, 1'b0, 1'b0);
        expect_now(1, 6, 2, ST_IDLE, 1'b0, 1'b0);
        drive(1, 1'b0, 8'd0, 1'b1, 1'b0);
        e0 = cyc;
        expect_now(1, 6, 2, ST_RUN, 1'b1, 1'b0);
        expect_done(1, e0 + 8);
        expect_done(1, e0 + 16);
        for (int i = 1; i <= 17; i++) begin
            tick_n(1);
            expect_now(1, 6, ((i / 4) % 2 == 1) ? 1 : 2, ST_RUN, 1'b1,
                       (i == 8 || i == 16));
        end
        drive(1, 1'b1, 8'd0, 1'b0, 1'b0);
        expect_now(1, 6, 0, ST_IDLE, 1'b0, 1'b0);

        tick_n(3);
        checks++;
        if (done_q0.size() != 0 || done_q1.size() != 0 || snap_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending done0=%0d done1=%0d snaps=%0d, want 0 0 0",
                     done_q0.size(), done_q1.size(), snap_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
